// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit counter predictor with target buffer, 0-cycle lookup.
// Optional saturating branch/mispredict counters when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic            pred_hit,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] correct_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [IDX_W-1:0]   if_idx, res_idx;
  logic [TAG_W-1:0]   if_tag, res_tag;
  logic [1:0]         ctr_cur, ctr_d;
  logic               res_hit, wr_ctr, wr_alloc;
  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[XLEN-1:IDX_W+2];
  assign res_idx     = res_pc[IDX_W+1:2];
  assign res_tag     = res_pc[XLEN-1:IDX_W+2];
  assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
  assign mispredict  = res_valid && ((res_taken != res_pred_taken) ||
                                     (res_taken && (res_pred_target != res_target)));
  assign correct_pc  = res_taken ? res_target : res_pc + XLEN'(4);
  assign res_hit     = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
  assign ctr_cur     = ctr_q[res_idx];
  // A miss can only reach here when taken (see wr_ctr), so it allocates weakly taken.
  assign ctr_d       = !res_hit  ? 2'b10 :
                       res_taken ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1) :
                                   ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1);
  assign wr_ctr      = res_valid && (res_hit || res_taken);
  assign wr_alloc    = res_valid && res_taken;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      if (wr_ctr) ctr_q[res_idx] <= ctr_d;
      if (wr_alloc) valid_q[res_idx] <= 1'b1;
    end
  end
  // Tag/target are meaningless while invalid, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_alloc) begin
      tag_q[res_idx]    <= res_tag;
      target_q[res_idx] <= res_target;
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (res_valid) begin
      stat_branches_q    <= stat_branches_q + {31'b0, stat_branches_q != '1};
      stat_mispredicts_q <= stat_mispredicts_q + {31'b0, mispredict && (stat_mispredicts_q != '1)};
    end
  end
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif
endmodule
